// File: rtl/resource_share_rr.sv
// resource_share_rr: round-robin share of one in-order pipelined unit.
// Optional packet lock: RESOURCE_SHARE_PKT_LOCK_EN.
module resource_share_rr #(
    parameter int NUM_IN       = 2,
    parameter int DAT_BITS     = 512,
    parameter int CTL_BITS     = 8,
    parameter int OVR_WRT_BIT  = 6,
    parameter int MAX_INFLIGHT = 16,
    localparam int IDW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int CW  = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_IN-1:0]            i_req_val,
    output logic [NUM_IN-1:0]            o_req_rdy,
    input  logic [NUM_IN*DAT_BITS-1:0]   i_req_dat,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
    input  logic [NUM_IN-1:0]            i_req_eop,
    output logic                         o_res_val,
    input  logic                         i_res_rdy,
    output logic [DAT_BITS-1:0]          o_res_dat,
    output logic [CTL_BITS-1:0]          o_res_ctl,
    input  logic                         i_ret_val,
    output logic                         o_ret_rdy,
    input  logic [DAT_BITS-1:0]          i_ret_dat,
    input  logic [CTL_BITS-1:0]          i_ret_ctl,
    output logic [NUM_IN-1:0]            o_rsp_val,
    input  logic [NUM_IN-1:0]            i_rsp_rdy,
    output logic [DAT_BITS-1:0]          o_rsp_dat,
    output logic [CTL_BITS-1:0]          o_rsp_ctl,
    output logic [CW-1:0]                o_inflight,
    output logic                         o_err
);

    localparam int AW = $clog2(MAX_INFLIGHT);

    logic [IDW-1:0]      rr;
    logic [NUM_IN-1:0]   cand;
    logic                found;
    logic                hi_any;
    logic [IDW-1:0]      hi_gnt;
    logic [IDW-1:0]      lo_gnt;
    logic [IDW-1:0]      gnt;
    logic                arb_en;
    logic                do_grant;
    logic [DAT_BITS-1:0] sel_dat;
    logic [CTL_BITS-1:0] sel_ctl;
    logic [CTL_BITS-1:0] stamp_ctl;
    logic [IDW-1:0]      ret_id;
    logic                ret_hs;
    logic                fifo_empty;
    logic                do_pop;
    logic [IDW-1:0]      tag_mem [MAX_INFLIGHT];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

`ifdef RESOURCE_SHARE_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] lock_id;
    logic [IDW-1:0] lock_nxt;

    // Lock state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            lock_id <= lock_nxt;
        end
    end

    // Lock next state: hold a source until its eop beat is granted
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_id;
        unique case (state)
            IDLE: begin
                if (do_grant && !i_req_eop[gnt]) begin
                    state_nxt = LOCKED;
                    lock_nxt  = gnt;
                end
            end
            LOCKED: begin
                if (do_grant && i_req_eop[gnt]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // While locked only the owning source may compete
    always_comb begin
        cand = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand[k] = i_req_val[k] &
                      ((state == IDLE) || (lock_id == IDW'(k)));
        end
    end
`else
    logic unused_eop;

    assign unused_eop = ^i_req_eop;
    assign cand       = i_req_val;
`endif

    assign arb_en = (!o_res_val || i_res_rdy) &&
                    (o_inflight < CW'(MAX_INFLIGHT));

    // Round-robin pick: lowest candidate at/above rr, else lowest overall
    always_comb begin
        found  = 1'b0;
        hi_any = 1'b0;
        hi_gnt = '0;
        lo_gnt = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (cand[k]) begin
                found  = 1'b1;
                lo_gnt = IDW'(k);
                if (k >= int'(rr)) begin
                    hi_any = 1'b1;
                    hi_gnt = IDW'(k);
                end
            end
        end
        gnt = hi_any ? hi_gnt : lo_gnt;
    end

    assign do_grant = arb_en && found;

    // Select granted beat, stamp id, drive one-hot ready
    always_comb begin
        sel_dat   = '0;
        sel_ctl   = '0;
        o_req_rdy = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (gnt == IDW'(k)) begin
                sel_dat      = i_req_dat[k*DAT_BITS +: DAT_BITS];
                sel_ctl      = i_req_ctl[k*CTL_BITS +: CTL_BITS];
                o_req_rdy[k] = do_grant;
            end
        end
        stamp_ctl = sel_ctl;
        stamp_ctl[OVR_WRT_BIT +: IDW] = gnt;
    end

    // Request output register and round-robin pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_val <= 1'b0;
            o_res_dat <= '0;
            o_res_ctl <= '0;
            rr        <= '0;
        end else if (do_grant) begin
            o_res_val <= 1'b1;
            o_res_dat <= sel_dat;
            o_res_ctl <= stamp_ctl;
            rr        <= (int'(gnt) == NUM_IN - 1) ? '0 : gnt + IDW'(1);
        end else if (i_res_rdy) begin
            o_res_val <= 1'b0;
        end
    end

    assign ret_id = i_ret_ctl[OVR_WRT_BIT +: IDW];

    // Return routing by id; unknown ids never handshake
    always_comb begin
        o_rsp_val = '0;
        o_ret_rdy = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (ret_id == IDW'(k)) begin
                o_rsp_val[k] = i_ret_val;
                o_ret_rdy    = i_rsp_rdy[k];
            end
        end
        o_rsp_ctl = i_ret_ctl;
        o_rsp_ctl[OVR_WRT_BIT +: IDW] = tag_mem[rd_ptr];
    end

    assign o_rsp_dat  = i_ret_dat;
    assign ret_hs     = i_ret_val && o_ret_rdy;
    assign fifo_empty = (o_inflight == '0);
    assign do_pop     = ret_hs && !fifo_empty;

    // Tag storage holds the original ctl bits the id overwrote
    always_ff @(posedge i_clk) begin
        if (do_grant) begin
            tag_mem[wr_ptr] <= sel_ctl[OVR_WRT_BIT +: IDW];
        end
    end

    // Credit count, tag pointers and sticky underflow error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_inflight <= '0;
            o_err      <= 1'b0;
        end else begin
            if (do_grant) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (ret_hs && fifo_empty) begin
                o_err <= 1'b1;
            end
            if (do_grant && !do_pop) begin
                o_inflight <= o_inflight + CW'(1);
            end else if (!do_grant && do_pop) begin
                o_inflight <= o_inflight - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_resource_share_rr.sv
// tb_resource_share_rr: directed checks of arbitration, credits, returns.
// Lock-mode expectations follow RESOURCE_SHARE_PKT_LOCK_EN.
module tb_resource_share_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_val;
    logic [2:0]  req_rdy;
    logic [47:0] req_dat;
    logic [23:0] req_ctl;
    logic [2:0]  req_eop;
    logic        res_val;
    logic        res_rdy;
    logic [15:0] res_dat;
    logic [7:0]  res_ctl;
    logic        ret_val;
    logic        ret_rdy;
    logic [15:0] ret_dat;
    logic [7:0]  ret_ctl;
    logic [2:0]  rsp_val;
    logic [2:0]  rsp_rdy;
    logic [15:0] rsp_dat;
    logic [7:0]  rsp_ctl;
    logic [2:0]  inflight;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    resource_share_rr #(
        .NUM_IN       (3),
        .DAT_BITS     (16),
        .CTL_BITS     (8),
        .OVR_WRT_BIT  (6),
        .MAX_INFLIGHT (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_val  (req_val),
        .o_req_rdy  (req_rdy),
        .i_req_dat  (req_dat),
        .i_req_ctl  (req_ctl),
        .i_req_eop  (req_eop),
        .o_res_val  (res_val),
        .i_res_rdy  (res_rdy),
        .o_res_dat  (res_dat),
        .o_res_ctl  (res_ctl),
        .i_ret_val  (ret_val),
        .o_ret_rdy  (ret_rdy),
        .i_ret_dat  (ret_dat),
        .i_ret_ctl  (ret_ctl),
        .o_rsp_val  (rsp_val),
        .i_rsp_rdy  (rsp_rdy),
        .o_rsp_dat  (rsp_dat),
        .o_rsp_ctl  (rsp_ctl),
        .o_inflight (inflight),
        .o_err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_rdy [4];
    logic [7:0] exp_ctl [2];
    logic [15:0] exp_dat [2];

    initial begin
        rst_n   = 1'b0;
        req_val = '0;
        req_dat = '0;
        req_ctl = '0;
        req_eop = '0;
        res_rdy = 1'b0;
        ret_val = 1'b0;
        ret_dat = '0;
        ret_ctl = '0;
        rsp_rdy = '0;
        #2;
        chk("rst_res_val", 32'(res_val), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_req_rdy", 32'(req_rdy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // alternation, 1-cycle latency, id stamp in [7:6]
        res_rdy = 1'b1;
        req_val = 3'b011;
        req_ctl = {8'h00, 8'h02, 8'h41};
        req_dat = {16'h0000, 16'hBBBB, 16'hAAAA};
        exp_ctl[0] = 8'h01;
        exp_ctl[1] = 8'h42;
        exp_dat[0] = 16'hAAAA;
        exp_dat[1] = 16'hBBBB;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_req_rdy", 32'(req_rdy), (i % 2) ? 3'b010 : 3'b001);
            tick();
            chk("alt_res_val", 32'(res_val), 1);
            chk("alt_res_ctl", 32'(res_ctl), 32'(exp_ctl[i % 2]));
            chk("alt_res_dat", 32'(res_dat), 32'(exp_dat[i % 2]));
            chk("alt_inflight", 32'(inflight), 32'(i + 1));
        end
        #1;
        chk("full_req_rdy", 32'(req_rdy), 0);
        tick();
        chk("full_res_val", 32'(res_val), 0);
        chk("full_inflight", 32'(inflight), 4);

        // one return frees a slot, grant follows next cycle
        ret_val = 1'b1;
        ret_ctl = 8'h01;
        ret_dat = 16'h5A5A;
        rsp_rdy = 3'b011;
        #1;
        chk("ret_rsp_val", 32'(rsp_val), 3'b001);
        chk("ret_ret_rdy", 32'(ret_rdy), 1);
        chk("ret_rsp_ctl", 32'(rsp_ctl), 'h41);
        chk("ret_rsp_dat", 32'(rsp_dat), 'h5A5A);
        chk("ret_req_rdy", 32'(req_rdy), 0);
        tick();
        chk("ret_inflight", 32'(inflight), 3);
        ret_val = 1'b0;
        #1;
        chk("refill_req_rdy", 32'(req_rdy), 3'b001);
        tick();
        chk("refill_inflight", 32'(inflight), 4);
        chk("refill_res_ctl", 32'(res_ctl), 'h01);
        req_val = '0;

        // source 0 not ready: return held
        ret_val = 1'b1;
        ret_ctl = 8'h01;
        rsp_rdy = 3'b110;
        #1;
        chk("hold_rsp_val", 32'(rsp_val), 3'b001);
        chk("hold_ret_rdy", 32'(ret_rdy), 0);
        tick();
        chk("hold_inflight", 32'(inflight), 4);
        rsp_rdy = 3'b111;
        #1;
        chk("rel_ret_rdy", 32'(ret_rdy), 1);
        chk("rel_rsp_ctl", 32'(rsp_ctl), 'h01);
        tick();
        chk("rel_inflight", 32'(inflight), 3);

        // id beyond NUM_IN stalls
        ret_ctl = 8'hC0;
        #1;
        chk("badid_rsp_val", 32'(rsp_val), 0);
        chk("badid_ret_rdy", 32'(ret_rdy), 0);
        tick();
        chk("badid_inflight", 32'(inflight), 3);
        chk("badid_err", 32'(err), 0);
        ret_val = 1'b0;

        // asynchronous reset with 3 in flight
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_inflight", 32'(inflight), 0);
        chk("arst_res_val", 32'(res_val), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // id stamp and restore
        req_val = 3'b010;
        req_ctl = {8'h00, 8'hC5, 8'h00};
        req_dat = {16'h0000, 16'h1234, 16'h0000};
        #1;
        chk("c5_req_rdy", 32'(req_rdy), 3'b010);
        tick();
        chk("c5_res_ctl", 32'(res_ctl), 'h45);
        chk("c5_res_dat", 32'(res_dat), 'h1234);
        chk("c5_inflight", 32'(inflight), 1);
        req_val = '0;
        ret_val = 1'b1;
        ret_ctl = 8'h45;
        ret_dat = 16'hBEEF;
        #1;
        chk("c5_rsp_val", 32'(rsp_val), 3'b010);
        chk("c5_rsp_ctl", 32'(rsp_ctl), 'hC5);
        chk("c5_rsp_dat", 32'(rsp_dat), 'hBEEF);
        tick();
        chk("c5_inflight_done", 32'(inflight), 0);
        chk("c5_err", 32'(err), 0);

        // return with empty tag FIFO
        ret_ctl = 8'h00;
        #1;
        chk("empty_ret_rdy", 32'(ret_rdy), 1);
        tick();
        chk("empty_err", 32'(err), 1);
        chk("empty_inflight", 32'(inflight), 0);
        ret_val = 1'b0;
        tick();
        tick();
        chk("sticky_err", 32'(err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_clears_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // packet beats from source 0 with source 1 competing
`ifdef RESOURCE_SHARE_PKT_LOCK_EN
        exp_rdy[0] = 3'b001;
        exp_rdy[1] = 3'b001;
        exp_rdy[2] = 3'b001;
        exp_rdy[3] = 3'b010;
`else
        exp_rdy[0] = 3'b001;
        exp_rdy[1] = 3'b010;
        exp_rdy[2] = 3'b001;
        exp_rdy[3] = 3'b010;
`endif
        req_val = 3'b011;
        req_ctl = {8'h00, 8'h02, 8'h41};
        for (int i = 0; i < 4; i++) begin
            req_eop = {1'b0, 1'b1, (i == 2)};
            #1;
            chk("pkt_req_rdy", 32'(req_rdy), 32'(exp_rdy[i]));
            tick();
        end
        chk("pkt_inflight", 32'(inflight), 4);
        req_val = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
